multichannel_gyrator: RTL and testbench

MULTICHANNEL_GYRATOR -- requirements
Module: multichannel_gyrator

---
 rtl/gyrator_pkg.sv | 31 +++
 rtl/gyr_sat.sv | 24 ++
 rtl/multichannel_gyrator.sv | 171 +++++++++++++++++
 tb/tb_multichannel_gyrator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gyrator_pkg.sv
// rtl/gyrator_pkg.sv - shared types and default parameters for the multichannel gyrator
package gyrator_pkg;

  localparam int W_DEF  = 16;
  localparam int CW_DEF = 16;
  localparam int AW_DEF = 32;
  localparam int CH_DEF = 4;

  typedef enum logic [1:0] {
    BYP = 2'd0,
    RES = 2'd1,
    IND = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // The reserved encoding 3 behaves as bypass.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return RES;
      2'd2:    return IND;
      default: return BYP;
    endcase
  endfunction

endpackage

// File: rtl/gyr_sat.sv
// rtl/gyr_sat.sv - signed saturating width reducer
module gyr_sat #(
  parameter int IW = 17,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din_i,
  output logic signed [OW-1:0] dout_o
);

  localparam logic signed [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

  generate
    if (IW <= OW) begin : g_extend
      assign dout_o = OW'(din_i);
    end else begin : g_clamp
      // The value fits when every bit above the output sign bit matches the input sign.
      logic fits;
      assign fits   = (din_i[IW-1:OW-1] == {(IW-OW+1){din_i[IW-1]}});
      assign dout_o = fits ? din_i[OW-1:0] : (din_i[IW-1] ? MIN_V : MAX_V);
    end
  endgenerate

endmodule

// File: rtl/multichannel_gyrator.sv
// rtl/multichannel_gyrator.sv - per-channel voltage-to-current gyrator with shared multiplier
module multichannel_gyrator
  import gyrator_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int CW  = CW_DEF,
  parameter int AW  = AW_DEF,
  parameter int CH  = CH_DEF,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   out_data,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_coef,
  input  logic [1:0]     cfg_mode,
  input  logic           cfg_clr
);

  state_e state_q, state_d;

  logic [CHW-1:0]       ch_q;
  logic signed [W-1:0]  data_q;
  logic signed [CW-1:0] coef_l_q;
  mode_e                mode_l_q;
  logic signed [W:0]    p_q;
  logic signed [W:0]    p_d;

  logic signed [CW-1:0] coef_q [CH];
  mode_e                mode_q [CH];
  logic signed [AW-1:0] acc_q  [CH];

  logic                 out_valid_q;
  logic [CHW-1:0]       out_ch_q;
  logic signed [W-1:0]  out_data_q;

  logic signed [AW:0]   acc_sum;
  logic signed [AW-1:0] acc_new;
  logic signed [W-1:0]  res_sat;
  logic signed [W-1:0]  ind_sat;
  logic signed [W-1:0]  result_d;
  logic                 in_ok;
  logic                 cfg_ok;
  logic                 in_take;

  generate
    if (CH == (1 << CHW)) begin : g_full_range
      assign in_ok  = 1'b1;
      assign cfg_ok = 1'b1;
    end else begin : g_part_range
      assign in_ok  = (in_ch  < CHW'(CH));
      assign cfg_ok = (cfg_ch < CHW'(CH));
    end
  endgenerate

  assign in_take = (state_q == IDLE) && in_valid && in_ok;

  // Single multiplier fed only by the latched sample and coefficient.
  assign p_d     = (W+1)'(((W+CW)'(data_q) * (W+CW)'(coef_l_q)) >>> (CW-1));
  assign acc_sum = (AW+1)'(acc_q[ch_q]) + (AW+1)'(p_q);

  gyr_sat #(.IW(AW+1), .OW(AW)) u_sat_acc (.din_i(acc_sum), .dout_o(acc_new));
  gyr_sat #(.IW(W+1),  .OW(W))  u_sat_res (.din_i(p_q),     .dout_o(res_sat));
  gyr_sat #(.IW(AW),   .OW(W))  u_sat_ind (.din_i(acc_new), .dout_o(ind_sat));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; out-of-range channels are accepted in IDLE and dropped.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_ok) state_d = MUL;
      end
      MUL:     state_d = ACC;
      ACC:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result selection by the mode latched at the input handshake.
  always_comb begin
    result_d = data_q;
    case (mode_l_q)
      RES:     result_d = res_sat;
      IND:     result_d = ind_sat;
      default: result_d = data_q;
    endcase
  end

  // Sample/config latch, product register and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q        <= '0;
      data_q      <= '0;
      coef_l_q    <= '0;
      mode_l_q    <= BYP;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      if (in_take) begin
        ch_q     <= in_ch;
        data_q   <= in_data;
        coef_l_q <= coef_q[in_ch];
        mode_l_q <= mode_q[in_ch];
      end
      if (state_q == MUL) p_q <= p_d;
      if (state_q == ACC) begin
        out_data_q  <= result_d;
        out_ch_q    <= ch_q;
        out_valid_q <= 1'b1;
      end else if ((state_q == OUT) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Per-channel coefficient and mode registers, writable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        coef_q[i] <= '0;
        mode_q[i] <= BYP;
      end
    end else if (cfg_we && cfg_ok) begin
      for (int i = 0; i < CH; i++) begin
        if (cfg_ch == CHW'(i)) begin
          coef_q[i] <= cfg_coef;
          mode_q[i] <= decode_mode(cfg_mode);
        end
      end
    end
  end

  // Per-channel accumulators; a clear beats a same-cycle inductive update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (cfg_clr && cfg_ok && (cfg_ch == CHW'(i))) begin
          acc_q[i] <= '0;
        end else if ((state_q == ACC) && (mode_l_q == IND) && (ch_q == CHW'(i))) begin
          acc_q[i] <= acc_new;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_multichannel_gyrator.sv
// tb/tb_multichannel_gyrator.sv - self-checking bench for multichannel_gyrator
module tb_multichannel_gyrator;

  localparam int W   = 16;
  localparam int CW  = 16;
  localparam int AW  = 32;
  localparam int CH  = 4;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [CHW-1:0] out_ch;
  logic [W-1:0]   out_data;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_coef = '0;
  logic [1:0]     cfg_mode = '0;
  logic           cfg_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cyc = 0;

  int     m_coef [CH];
  int     m_mode [CH];
  longint m_acc  [CH];

  multichannel_gyrator #(.W(W), .CW(CW), .AW(AW), .CH(CH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_coef(cfg_coef), .cfg_mode(cfg_mode),
    .cfg_clr(cfg_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int n);
    longint hi = (longint'(1) <<< (n - 1)) - 1;
    longint lo = -(longint'(1) <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_coef[i] = 0;
      m_mode[i] = 0;
      m_acc[i]  = 0;
    end
  endfunction

  // Voltage in, current out: scale by the Q1.(CW-1) coefficient with floor rounding.
  function automatic longint model_step(input int ch, input int data);
    longint prod = longint'(data) * longint'(m_coef[ch]);
    longint d    = longint'(1) <<< (CW - 1);
    longint p    = prod / d;
    if ((prod % d != 0) && (prod < 0)) p = p - 1;
    case (m_mode[ch])
      1: return sat(p, W);
      2: begin
        m_acc[ch] = sat(m_acc[ch] + p, AW);
        return sat(m_acc[ch], W);
      end
      default: return longint'(data);
    endcase
  endfunction

  task automatic cfg_write(input int ch, input int coef, input int mode);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_coef = CW'(coef); cfg_mode = 2'(mode);
    @(negedge clk);
    cfg_we = 1'b0;
    m_coef[ch] = coef;
    m_mode[ch] = mode;
  endtask

  task automatic cfg_clear(input int ch);
    @(negedge clk);
    cfg_clr = 1'b1; cfg_ch = CHW'(ch);
    @(negedge clk);
    cfg_clr = 1'b0;
    m_acc[ch] = 0;
  endtask

  // Returns at the falling edge of the cycle after the handshake.
  task automatic offer(input int ch, input int data);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_ch = CHW'(ch); in_data = W'(data);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    hs_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int ech, input longint edata, input string tag,
                         input bit clr_in_acc);
    int lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
      cfg_we  = 1'b0;
      cfg_clr = 1'b0;
      if (clr_in_acc && lat == 2) begin
        cfg_clr = 1'b1;
        cfg_ch  = CHW'(ech);
      end
    end
    cfg_we  = 1'b0;
    cfg_clr = 1'b0;
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, $signed(out_data), edata);
    check({tag, "_ch"}, out_ch, ech);
  endtask

  task automatic send(input int ch, input int data, input string tag);
    longint e;
    offer(ch, data);
    e = model_step(ch, data);
    collect(ch, e, tag, 1'b0);
  endtask

  initial begin
    longint e;
    int prev_hs;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Reset in the MUL cycle discards the sample.
    cfg_write(0, 16'h4000, 1);
    offer(0, 1000);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_ch", out_ch, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_output", out_valid, 0);
      @(negedge clk);
    end

    // Resistive channel.
    cfg_write(0, 16'h4000, 1);
    offer(0, 1000);
    void'(model_step(0, 1000));
    collect(0, 500, "res_ch0", 1'b0);

    // Inductive accumulation and idle clear.
    cfg_write(1, 16'h4000, 2);
    send(1, 1000, "ind_a");
    check("ind_a_spec", $signed(out_data), 500);
    send(1, 1000, "ind_b");
    check("ind_b_spec", $signed(out_data), 1000);
    send(1, 1000, "ind_c");
    check("ind_c_spec", $signed(out_data), 1500);
    cfg_clear(1);
    send(1, 1000, "ind_after_clr");
    check("ind_after_clr_spec", $signed(out_data), 500);

    // Saturation without wrap.
    cfg_write(2, 16'h7FFF, 2);
    offer(2, 32767);
    void'(model_step(2, 32767));
    collect(2, 32766, "sat_first", 1'b0);
    for (int k = 0; k < 3; k++) begin
      offer(2, 32767);
      void'(model_step(2, 32767));
      collect(2, 32767, "sat_clamp", 1'b0);
    end

    // Clear landing in the ACC cycle of the same channel.
    offer(1, 1000);
    e = model_step(1, 1000);
    collect(1, e, "clr_in_acc", 1'b1);
    check("clr_in_acc_spec", $signed(out_data), 1000);
    m_acc[1] = 0;
    send(1, 1000, "after_acc_clr");
    check("after_acc_clr_spec", $signed(out_data), 500);

    // Output backpressure with a second sample waiting; reserved mode acts as bypass.
    cfg_write(3, 0, 3);
    out_ready = 1'b0;
    offer(0, 1000);
    void'(model_step(0, 1000));
    collect(0, 500, "hold_first", 1'b0);
    in_valid = 1'b1; in_ch = CHW'(3); in_data = W'(-7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", $signed(out_data), 500);
      check("hold_ch", out_ch, 0);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    offer(3, -7);
    void'(model_step(3, -7));
    collect(3, -7, "byp_neg", 1'b0);

    // Randomized traffic with config changes, including writes while a sample is in flight.
    prev_hs = -1;
    for (int it = 0; it < 40; it++) begin
      int ch, data, ncoef, nmode;
      ch = int'($urandom_range(0, CH - 1));
      data = int'($urandom_range(0, 65535)) - 32768;
      if (it % 7 == 0) data = (it % 2 == 0) ? 32767 : -32768;
      if ($urandom_range(0, 3) == 0) begin
        cfg_write(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 3)));
        prev_hs = -1;
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_clear(int'($urandom_range(0, CH - 1)));
        prev_hs = -1;
      end
      offer(ch, data);
      e = model_step(ch, data);
      if (prev_hs >= 0) check("throughput_gap", hs_cyc - prev_hs, 4);
      prev_hs = hs_cyc;
      if ($urandom_range(0, 2) == 0) begin
        ncoef = int'($urandom_range(0, 65535)) - 32768;
        nmode = int'($urandom_range(0, 3));
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_coef = CW'(ncoef); cfg_mode = 2'(nmode);
        m_coef[ch] = ncoef;
        m_mode[ch] = nmode;
      end
      collect(ch, e, "rand", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
